// File: rtl/chess_pkg.sv
// Shared move-generation types: 19-bit move slot layout, 8-slot FIFO word, scheduler states.
package chess_pkg;

  localparam int unsigned SLOT_W       = 19;
  localparam int unsigned SLOTS        = 8;
  localparam int unsigned WORD_W       = SLOT_W * SLOTS;
  localparam int unsigned FLAG_INVALID = 18;
  localparam int unsigned FROM_LSB     = 6;
  localparam int unsigned TO_LSB       = 0;
  localparam int unsigned FLAG_INV_BIT = 6;

  typedef struct packed {
    logic [6:0] flags;
    logic [5:0] from;
    logic [5:0] to;
  } move_t;

  typedef move_t [SLOTS-1:0] word_t;

  localparam move_t IMOV = '{flags: 7'h40, from: 6'h00, to: 6'h00};

  typedef enum logic [2:0] {
    IDLE,
    RST,
    WAIT,
    SCAN,
    READ,
    LATCH,
    EMIT,
    FIN
  } state_t;

  function automatic logic move_invalid(input move_t m);
    return m.flags[FLAG_INV_BIT];
  endfunction

endpackage

// File: rtl/move_gen_scheduler_sq_pick.sv
// Lowest-set-bit encoder over the per-square request vector.
module sq_pick #(
  parameter int unsigned NSQ   = 64,
  parameter int unsigned IDX_W = $clog2(NSQ)
) (
  input  logic [NSQ-1:0]   req,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  // Descending scan so the lowest set index wins.
  always_comb begin
    idx = '0;
    any = 1'b0;
    for (int i = int'(NSQ) - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx = IDX_W'(i);
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/move_gen_scheduler.sv
// Move-generation pass sequencer: unit reset, wait for done, drain square FIFOs, stream valid moves.
// Optional WAIT watchdog enabled by defining MOVEGEN_WDOG_EN.
module move_gen_scheduler
  import chess_pkg::*;
#(
  parameter int unsigned NSQ         = 64,
  parameter int unsigned RST_CYCLES  = 2,
  parameter int unsigned CNT_W       = 10,
  parameter int unsigned WDOG_CYCLES = 1024
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  output logic                    unit_reset,
  input  logic [NSQ-1:0]          unit_done,
  input  logic [NSQ-1:0]          fifo_empty,
  output logic [NSQ-1:0]          fifo_rden,
  output logic [$clog2(NSQ)-1:0]  fifo_sel,
  input  logic [WORD_W-1:0]       fifo_q,
  output logic                    mv_valid,
  input  logic                    mv_ready,
  output move_t                   mv_data,
  output logic [CNT_W-1:0]        move_count,
  output logic                    busy,
  output logic                    gen_done,
  output logic                    err_timeout
);

  localparam int unsigned IDX_W  = $clog2(NSQ);
  localparam int unsigned RC_W   = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam int unsigned SI_W   = $clog2(SLOTS);

  state_t            state, state_d;
  logic [RC_W-1:0]   rst_cnt, rst_cnt_d;
  logic [IDX_W-1:0]  ptr, ptr_d, fifo_sel_d, pick_idx;
  logic [SI_W-1:0]   slot, slot_d;
  word_t             word, word_d;
  move_t             cur, mv_data_d;
  logic              mv_valid_d, err_timeout_d, pick_any;
  logic [CNT_W-1:0]  move_count_d;

`ifdef MOVEGEN_WDOG_EN
  localparam int unsigned WD_W = $clog2(WDOG_CYCLES + 1);
  logic [WD_W-1:0]   wdog_cnt, wdog_cnt_d;
`endif

  sq_pick #(.NSQ(NSQ), .IDX_W(IDX_W)) u_pick (
    .req (~fifo_empty),
    .idx (pick_idx),
    .any (pick_any)
  );

  // Next-state and datapath updates.
  always_comb begin
    state_d       = state;
    rst_cnt_d     = rst_cnt;
    ptr_d         = ptr;
    slot_d        = slot;
    word_d        = word;
    fifo_sel_d    = fifo_sel;
    mv_valid_d    = mv_valid;
    mv_data_d     = mv_data;
    move_count_d  = move_count;
    err_timeout_d = err_timeout;
`ifdef MOVEGEN_WDOG_EN
    wdog_cnt_d    = wdog_cnt;
`endif
    cur = word[slot];
    case (state)
      IDLE: begin
        if (start) begin
          state_d       = RST;
          rst_cnt_d     = '0;
          move_count_d  = '0;
          err_timeout_d = 1'b0;
`ifdef MOVEGEN_WDOG_EN
          wdog_cnt_d    = '0;
`endif
        end
      end
      RST: begin
        if (rst_cnt == RC_W'(RST_CYCLES - 1)) state_d = WAIT;
        else rst_cnt_d = rst_cnt + RC_W'(1);
      end
      WAIT: begin
        if (&unit_done) state_d = SCAN;
`ifdef MOVEGEN_WDOG_EN
        else if (wdog_cnt == WD_W'(WDOG_CYCLES - 1)) begin
          state_d       = SCAN;
          err_timeout_d = 1'b1;
        end else wdog_cnt_d = wdog_cnt + WD_W'(1);
`endif
      end
      SCAN: begin
        if (!pick_any) state_d = FIN;
        else begin
          ptr_d      = pick_idx;
          fifo_sel_d = pick_idx;
          state_d    = READ;
        end
      end
      READ:  state_d = LATCH;
      LATCH: begin
        word_d  = word_t'(fifo_q);
        slot_d  = '0;
        state_d = EMIT;
      end
      EMIT: begin
        // A presented move advances only on handshake; invalid slots are skipped unpresented.
        if (mv_valid) begin
          if (mv_ready) begin
            mv_valid_d = 1'b0;
            if (move_count != '1) move_count_d = move_count + CNT_W'(1);
            if (slot == SI_W'(SLOTS - 1)) state_d = SCAN;
            else slot_d = slot + SI_W'(1);
          end
        end else if (move_invalid(cur)) begin
          if (slot == SI_W'(SLOTS - 1)) state_d = SCAN;
          else slot_d = slot + SI_W'(1);
        end else begin
          mv_valid_d = 1'b1;
          mv_data_d  = cur;
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      rst_cnt     <= '0;
      ptr         <= '0;
      slot        <= '0;
      word        <= '0;
      unit_reset  <= 1'b0;
      fifo_rden   <= '0;
      fifo_sel    <= '0;
      mv_valid    <= 1'b0;
      mv_data     <= '0;
      move_count  <= '0;
      busy        <= 1'b0;
      gen_done    <= 1'b0;
      err_timeout <= 1'b0;
`ifdef MOVEGEN_WDOG_EN
      wdog_cnt    <= '0;
`endif
    end else begin
      state       <= state_d;
      rst_cnt     <= rst_cnt_d;
      ptr         <= ptr_d;
      slot        <= slot_d;
      word        <= word_d;
      unit_reset  <= (state_d == RST);
      fifo_rden   <= (state_d == READ) ? (NSQ'(1) << ptr_d) : '0;
      fifo_sel    <= fifo_sel_d;
      mv_valid    <= mv_valid_d;
      mv_data     <= mv_data_d;
      move_count  <= move_count_d;
      busy        <= (state_d != IDLE);
      gen_done    <= (state_d == FIN);
      err_timeout <= err_timeout_d;
`ifdef MOVEGEN_WDOG_EN
      wdog_cnt    <= wdog_cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_move_gen_scheduler.sv
// Directed bench for move_gen_scheduler: FIFO model, expected-move scoreboard, pass vector table.
module tb_move_gen_scheduler;

  localparam int NSQ = 64;
  localparam int RSTC = 2;
  localparam int WDOG = 16;

  logic           clk = 1'b0;
  logic           reset, start, unit_reset, mv_valid, mv_ready, busy, gen_done, err_timeout;
  logic [NSQ-1:0] unit_done, fifo_empty, fifo_rden;
  logic [5:0]     fifo_sel;
  logic [151:0]   fifo_q;
  logic [18:0]    mv_data;
  logic [9:0]     move_count;

  always #5 clk = ~clk;

  move_gen_scheduler #(.NSQ(NSQ), .RST_CYCLES(RSTC), .CNT_W(10), .WDOG_CYCLES(WDOG)) dut (
    .clk(clk), .reset(reset), .start(start), .unit_reset(unit_reset), .unit_done(unit_done),
    .fifo_empty(fifo_empty), .fifo_rden(fifo_rden), .fifo_sel(fifo_sel), .fifo_q(fifo_q),
    .mv_valid(mv_valid), .mv_ready(mv_ready), .mv_data(mv_data), .move_count(move_count),
    .busy(busy), .gen_done(gen_done), .err_timeout(err_timeout)
  );

  typedef struct {
    int lo, hi, step, nw;
    logic [7:0] mask;
    int rmode, exp_cnt, exp_rd;
  } vec_t;
  vec_t tbl [7];

  int nvec = 0, nfail = 0;
  logic [151:0] mem [NSQ][4];
  int wrp [NSQ], rdp [NSQ], cnt [NSQ];
  logic [18:0] exp_mv [$];
  int exp_rd [$];
  int cyc, ur_cyc, first_rd, first_err, rd_cnt, gd_cnt;
  logic prev_valid, prev_ready;
  logic [18:0] prev_data;

  always_comb for (int i = 0; i < NSQ; i++) fifo_empty[i] = (cnt[i] == 0);

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] want);
    nvec++;
    if (got !== want) begin
      nfail++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < NSQ; i++) begin wrp[i] = 0; rdp[i] = 0; cnt[i] = 0; end
    exp_mv.delete();
    exp_rd.delete();
    fifo_q = '0;
  endtask

  // Valid slot k: flags=k, from=sq, to=sq+8+8w+(ordinal among valid slots); invalid slots carry junk.
  task automatic load_sq(input int sq, input int nw, input logic [7:0] mask);
    logic [151:0] w;
    logic [18:0] m;
    int vi;
    for (int wi = 0; wi < nw; wi++) begin
      vi = 0;
      for (int k = 0; k < 8; k++) begin
        if (mask[k]) begin
          m = {7'(k), 6'(sq), 6'(sq + 8 + 8 * wi + vi)};
          vi++;
          exp_mv.push_back(m);
        end else m = {7'h40 | 7'(k), 6'h3F, 6'(k)};
        w[k*19 +: 19] = m;
      end
      mem[sq][wrp[sq]] = w;
      wrp[sq]++;
      cnt[sq]++;
      exp_rd.push_back(sq);
    end
  endtask

  task automatic start_pass();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0; ur_cyc = 0; first_rd = -1; first_err = -1; rd_cnt = 0; gd_cnt = 0;
    prev_valid = 1'b0; prev_ready = 1'b0; prev_data = '0;
  endtask

  // One negedge: drive ready, check stall/read/handshake, serve the FIFO model.
  task automatic monitor_cycle(input int rmode);
    int idx;
    case (rmode)
      0: mv_ready = 1'b1;
      1: mv_ready = ((cyc % 3) != 1);
      default: mv_ready = 1'b0;
    endcase
    if (prev_valid && !prev_ready) check("stall_hold", {mv_valid, mv_data}, {1'b1, prev_data});
    if (unit_reset) ur_cyc++;
    if (err_timeout && first_err < 0) first_err = cyc;
    if (fifo_rden != '0) begin
      idx = -1;
      for (int i = 0; i < NSQ; i++) if (fifo_rden[i] && idx < 0) idx = i;
      nvec++;
      if ($countones(fifo_rden) != 1 || fifo_empty[idx] || exp_rd.size() == 0 || exp_rd[0] != idx) begin
        nfail++;
        $display("FAIL read: got rden %0h (sq %0d) want sq %0d", fifo_rden, idx,
                 (exp_rd.size() > 0) ? exp_rd[0] : -1);
      end
      if (exp_rd.size() > 0) void'(exp_rd.pop_front());
      if (first_rd < 0) first_rd = cyc;
      rd_cnt++;
      if (cnt[idx] > 0) begin
        fifo_q = mem[idx][rdp[idx]];
        rdp[idx]++;
        cnt[idx]--;
      end
    end
    if (mv_valid && mv_ready) begin
      if (exp_mv.size() == 0) check("extra_move", {109'd0, mv_data}, 128'h7FFFF_FFFF);
      else check("move_data", {109'd0, mv_data}, {109'd0, exp_mv.pop_front()});
    end
    if (gen_done) gd_cnt++;
    prev_valid = mv_valid;
    prev_ready = mv_ready;
    prev_data  = mv_data;
    cyc++;
  endtask

  task automatic finish_pass(input int rmode, input int exp_cnt, input int exp_rdn, input int exp_err);
    int budget = 6000;
    bit done = 1'b0;
    while (!done && budget > 0) begin
      monitor_cycle(rmode);
      if (gen_done) done = 1'b1;
      @(negedge clk);
      budget--;
    end
    check("pass_timeout", done, 1'b1);
    check("done_pulse", {gen_done, busy, 32'(gd_cnt)}, {2'b00, 32'd1});
    check("move_count", move_count, exp_cnt);
    check("read_count", rd_cnt, exp_rdn);
    check("leftover", {32'(exp_mv.size()), 32'(exp_rd.size())}, 64'd0);
    check("unit_reset_len", ur_cyc, RSTC);
    check("err_timeout", err_timeout, exp_err);
    if (exp_rdn > 0) check("first_read_lat", (first_rd >= RSTC + 2), 1'b1);
  endtask

  task automatic run_vec(input int v);
    clear_model();
    if (tbl[v].nw > 0)
      for (int sq = tbl[v].lo; sq <= tbl[v].hi; sq += tbl[v].step) load_sq(sq, tbl[v].nw, tbl[v].mask);
    start_pass();
    finish_pass(tbl[v].rmode, tbl[v].exp_cnt, tbl[v].exp_rd, 0);
  endtask

  task automatic check_reset_vals(input string name);
    check(name, {unit_reset, fifo_rden, fifo_sel, mv_valid, mv_data, move_count, busy, gen_done, err_timeout},
          '0);
  endtask

  initial begin
    int b;
    tbl[0] = '{lo: 0,  hi: 0,  step: 1,  nw: 0, mask: 8'h00, rmode: 0, exp_cnt: 0,    exp_rd: 0};
    tbl[1] = '{lo: 12, hi: 12, step: 1,  nw: 1, mask: 8'h09, rmode: 0, exp_cnt: 2,    exp_rd: 1};
    tbl[2] = '{lo: 5,  hi: 40, step: 35, nw: 2, mask: 8'hA6, rmode: 0, exp_cnt: 16,   exp_rd: 4};
    tbl[3] = '{lo: 63, hi: 63, step: 1,  nw: 1, mask: 8'h00, rmode: 0, exp_cnt: 0,    exp_rd: 1};
    tbl[4] = '{lo: 0,  hi: 63, step: 63, nw: 1, mask: 8'h80, rmode: 1, exp_cnt: 2,    exp_rd: 2};
    tbl[5] = '{lo: 7,  hi: 9,  step: 1,  nw: 3, mask: 8'hFF, rmode: 1, exp_cnt: 72,   exp_rd: 9};
    tbl[6] = '{lo: 0,  hi: 63, step: 1,  nw: 2, mask: 8'hFF, rmode: 0, exp_cnt: 1023, exp_rd: 128};

    reset = 1'b1; start = 1'b0; mv_ready = 1'b0; unit_done = '1;
    clear_model();
    repeat (3) @(negedge clk);
    check_reset_vals("reset_state");
    reset = 1'b0;
    @(negedge clk);

    for (int v = 0; v < 7; v++) run_vec(v);

    // Downstream stall on the first valid move.
    clear_model();
    load_sq(30, 1, 8'h06);
    start_pass();
    b = 0;
    while (!mv_valid && b < 50) begin monitor_cycle(2); @(negedge clk); b++; end
    check("stall_reach", mv_valid, 1'b1);
    for (int i = 0; i < 10; i++) begin
      monitor_cycle(2);
      check("stall_quiet", {move_count, fifo_rden}, '0);
      @(negedge clk);
    end
    finish_pass(0, 2, 1, 0);

    // Reset while presenting a move aborts the pass.
    clear_model();
    load_sq(20, 2, 8'hFF);
    start_pass();
    b = 0;
    while (!mv_valid && b < 50) begin monitor_cycle(2); @(negedge clk); b++; end
    check("abort_reach", mv_valid, 1'b1);
    reset = 1'b1;
    @(negedge clk);
    check_reset_vals("abort_reset");
    reset = 1'b0;
    @(negedge clk);
    run_vec(1);

    // Square 3 never reports done.
    clear_model();
    load_sq(3, 1, 8'h01);
    unit_done[3] = 1'b0;
    start_pass();
`ifdef MOVEGEN_WDOG_EN
    finish_pass(0, 1, 1, 1);
    check("wdog_time", first_err, RSTC + WDOG);
`else
    for (int i = 0; i < 30; i++) begin monitor_cycle(0); @(negedge clk); end
    check("wait_hold", {32'(rd_cnt), busy, gen_done}, {32'd0, 1'b1, 1'b0});
    unit_done[3] = 1'b1;
    finish_pass(0, 1, 1, 0);
`endif
    unit_done = '1;
    run_vec(2);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
